// File: rtl/culsans_sim_pkg.sv
// Shared definitions for the Culsans simulation/emulation control slice.
//   sim_state_e     : sequencing states of the control FSM
//   EXIT_VALID_BIT  : bit position of the valid flag in an exit word
//   EXIT_CODE_SHIFT : LSB position of the exit code field in an exit word
package culsans_sim_pkg;

    typedef enum logic [1:0] {
        HOLD = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sim_state_e;

    localparam int unsigned EXIT_VALID_BIT  = 0;
    localparam int unsigned EXIT_CODE_SHIFT = 1;

endpackage

// File: rtl/culsans_clk_div.sv
// Even clock divider producing a 50% duty output.
//   clk_i : input clock
//   rst   : asynchronous active-low reset
//   clk_o : divided output, period Div input cycles, low after reset
// The output toggles each time the counter reaches Div/2-1, so the first
// rise comes Div/2 edges after reset release.
module culsans_clk_div #(
    parameter int unsigned Div = 2442
) (
    input  logic clk_i,
    input  logic rst,
    output logic clk_o
);

    localparam int unsigned CntW = (Div > 1) ? $clog2(Div) : 1;
    localparam logic [CntW-1:0] HalfLast = CntW'(Div / 2 - 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            clk_q, clk_d;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        clk_d = clk_q;
        if (cnt_q == HalfLast) begin
            cnt_d = '0;
            clk_d = ~clk_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
            clk_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            clk_q <= clk_d;
        end
    end

    assign clk_o = clk_q;

endmodule

// File: rtl/culsans_sim_ctrl.sv
// Simulation/emulation control for the Culsans platform.
// Sequences the SoC reset, generates the RTC tick and turns per-hart exit
// words into one registered verdict (pass / fail with code+hart / timeout).
//   clk_i       : main clock
//   rst         : asynchronous active-low reset
//   core_rst_no : sequenced SoC reset, active-low, released after RstHoldCycles
//   rtc_o       : RTC clock, period RtcDiv clk cycles
//   exit_i      : per-hart exit words, bit 0 valid, upper bits code
//   done_o      : verdict valid (sticky)
//   pass_o      : run finished with all relevant codes zero
//   timeout_o   : run finished by watchdog
//   fail_code_o : code of the failing hart, 0 otherwise
//   fail_hart_o : index of the failing hart
//   reported_o  : sticky per-hart "has reported" flags
module culsans_sim_ctrl
    import culsans_sim_pkg::*;
#(
    parameter int unsigned NumHarts      = 2,
    parameter int unsigned ExitWidth     = 32,
    parameter int unsigned RstHoldCycles = 16,
    parameter int unsigned RtcDiv        = 2442,
    parameter int unsigned TimeoutCycles = 0,
    parameter int unsigned WaitAll       = 1,
    localparam int unsigned HartW = (NumHarts > 1) ? $clog2(NumHarts) : 1
) (
    input  logic                                clk_i,
    input  logic                                rst,
    output logic                                core_rst_no,
    output logic                                rtc_o,
    input  logic [NumHarts-1:0][ExitWidth-1:0]  exit_i,
    output logic                                done_o,
    output logic                                pass_o,
    output logic                                timeout_o,
    output logic [ExitWidth-2:0]                fail_code_o,
    output logic [HartW-1:0]                    fail_hart_o,
    output logic [NumHarts-1:0]                 reported_o
);

    localparam int unsigned CodeW = ExitWidth - 1;
    localparam int unsigned HoldW = $clog2(RstHoldCycles + 1);
    localparam int unsigned WdW   = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
    localparam logic [HoldW-1:0] HoldLast = HoldW'(RstHoldCycles - 1);
    localparam logic [WdW-1:0]   WdLast   = WdW'((TimeoutCycles > 0) ? TimeoutCycles - 1 : 0);

    sim_state_e            state_q, state_d;
    logic [HoldW-1:0]      hold_cnt_q, hold_cnt_d;
    logic [WdW-1:0]        wd_cnt_q, wd_cnt_d;
    logic [NumHarts-1:0]   reported_q, reported_d;
    logic                  core_rst_n_q, core_rst_n_d;
    logic                  done_q, done_d;
    logic                  pass_q, pass_d;
    logic                  timeout_q, timeout_d;
    logic [CodeW-1:0]      fail_code_q, fail_code_d;
    logic [HartW-1:0]      fail_hart_q, fail_hart_d;

    logic [CodeW-1:0]      code_w [NumHarts];
    logic [NumHarts-1:0]   new_valid;
    logic [NumHarts-1:0]   new_fail;
    logic [NumHarts-1:0]   new_pass;

    logic                  sel_found;
    logic [CodeW-1:0]      sel_code;
    logic [HartW-1:0]      sel_hart;

    // A channel only counts on the first cycle its valid bit is seen.
    for (genvar gi = 0; gi < NumHarts; gi++) begin : g_hart
        assign code_w[gi]    = exit_i[gi][ExitWidth-1:EXIT_CODE_SHIFT];
        assign new_valid[gi] = exit_i[gi][EXIT_VALID_BIT] & ~reported_q[gi];
        assign new_fail[gi]  = new_valid[gi] & (|code_w[gi]);
        assign new_pass[gi]  = new_valid[gi] & ~(|code_w[gi]);
    end

    // Lowest-index failing hart wins when several fail together.
    always_comb begin
        sel_found = 1'b0;
        sel_code  = '0;
        sel_hart  = '0;
        for (int h = 0; h < NumHarts; h++) begin
            if (new_fail[h] && !sel_found) begin
                sel_found = 1'b1;
                sel_code  = code_w[h];
                sel_hart  = HartW'(h);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        hold_cnt_d   = hold_cnt_q;
        wd_cnt_d     = wd_cnt_q;
        reported_d   = reported_q;
        core_rst_n_d = core_rst_n_q;
        done_d       = done_q;
        pass_d       = pass_q;
        timeout_d    = timeout_q;
        fail_code_d  = fail_code_q;
        fail_hart_d  = fail_hart_q;
        case (state_q)
            HOLD: begin
                if (hold_cnt_q == HoldLast) begin
                    state_d      = RUN;
                    core_rst_n_d = 1'b1;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            RUN: begin
                reported_d = reported_q | new_valid;
                // With the watchdog disabled the counter is held so it never wraps.
                if (TimeoutCycles != 0) begin
                    wd_cnt_d = wd_cnt_q + 1'b1;
                end
                // Priority: fail, then pass, then watchdog.
                if (sel_found) begin
                    state_d     = DONE;
                    done_d      = 1'b1;
                    fail_code_d = sel_code;
                    fail_hart_d = sel_hart;
                end else if ((WaitAll != 0) ? (&reported_d) : (|new_pass)) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    pass_d  = 1'b1;
                end else if ((TimeoutCycles != 0) && (wd_cnt_q == WdLast)) begin
                    state_d   = DONE;
                    done_d    = 1'b1;
                    timeout_d = 1'b1;
                end
            end
            DONE: begin
            end
            default: begin
                state_d = HOLD;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst) begin
        if (!rst) begin
            state_q      <= HOLD;
            hold_cnt_q   <= '0;
            wd_cnt_q     <= '0;
            reported_q   <= '0;
            core_rst_n_q <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            timeout_q    <= 1'b0;
            fail_code_q  <= '0;
            fail_hart_q  <= '0;
        end else begin
            state_q      <= state_d;
            hold_cnt_q   <= hold_cnt_d;
            wd_cnt_q     <= wd_cnt_d;
            reported_q   <= reported_d;
            core_rst_n_q <= core_rst_n_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            timeout_q    <= timeout_d;
            fail_code_q  <= fail_code_d;
            fail_hart_q  <= fail_hart_d;
        end
    end

    culsans_clk_div #(
        .Div (RtcDiv)
    ) u_rtc_div (
        .clk_i (clk_i),
        .rst   (rst),
        .clk_o (rtc_o)
    );

    // The SoC reset comes from its own flop rather than a state decode so
    // it cannot glitch on state transitions.
    assign core_rst_no = core_rst_n_q;
    assign done_o      = done_q;
    assign pass_o      = pass_q;
    assign timeout_o   = timeout_q;
    assign fail_code_o = fail_code_q;
    assign fail_hart_o = fail_hart_q;
    assign reported_o  = reported_q;

endmodule

// File: tb/tb_culsans_sim_ctrl.sv
// Bench for culsans_sim_ctrl: two instances (WaitAll=1 with a 20-cycle
// watchdog, WaitAll=0 without) checked every cycle against an event-level
// model counting edges since reset release, plus literal spot checks.
module tb_culsans_sim_ctrl;

    localparam int HOLDC = 4;
    localparam int DIVC  = 10;

    logic clk;
    logic rst;
    logic [1:0][31:0] exit_a, exit_b;

    logic crn_a, rtc_a, done_a, pass_a, to_a;
    logic [30:0] code_a;
    logic hart_a;
    logic [1:0] rep_a;
    logic crn_b, rtc_b, done_b, pass_b, to_b;
    logic [30:0] code_b;
    logic hart_b;
    logic [1:0] rep_b;

    int checks = 0;
    int errors = 0;

    culsans_sim_ctrl #(
        .NumHarts(2), .ExitWidth(32), .RstHoldCycles(HOLDC), .RtcDiv(DIVC),
        .TimeoutCycles(20), .WaitAll(1)
    ) dut_a (
        .clk_i(clk), .rst(rst), .core_rst_no(crn_a), .rtc_o(rtc_a),
        .exit_i(exit_a), .done_o(done_a), .pass_o(pass_a), .timeout_o(to_a),
        .fail_code_o(code_a), .fail_hart_o(hart_a), .reported_o(rep_a)
    );

    culsans_sim_ctrl #(
        .NumHarts(2), .ExitWidth(32), .RstHoldCycles(HOLDC), .RtcDiv(DIVC),
        .TimeoutCycles(0), .WaitAll(0)
    ) dut_b (
        .clk_i(clk), .rst(rst), .core_rst_no(crn_b), .rtc_o(rtc_b),
        .exit_i(exit_b), .done_o(done_b), .pass_o(pass_b), .timeout_o(to_b),
        .fail_code_o(code_b), .fail_hart_o(hart_b), .reported_o(rep_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: per instance, edges since release and the verdict so far.
    int       e     [2];
    bit       md    [2];
    bit       mp    [2];
    bit       mt    [2];
    int       mcode [2];
    int       mhart [2];
    bit [1:0] mrep  [2];
    int       to_lim [2] = '{20, 0};
    bit       wa     [2] = '{1'b1, 1'b0};

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            e[m] = 0; md[m] = 0; mp[m] = 0; mt[m] = 0;
            mcode[m] = 0; mhart[m] = 0; mrep[m] = '0;
        end
    endtask

    // One rising edge: if the block had already left reset hold, that edge
    // closes a RUN cycle (unless the verdict is already in).
    task automatic model_step(input int m, input logic [1:0][31:0] ex);
        int  k;
        bit  f;
        bit  anyzero;
        f = 0;
        anyzero = 0;
        if (e[m] >= HOLDC && !md[m]) begin
            k = e[m] - HOLDC + 1;
            for (int h = 0; h < 2; h++) begin
                if (ex[h][0] && !mrep[m][h]) begin
                    mrep[m][h] = 1'b1;
                    if (ex[h][31:1] != 0) begin
                        if (!f) begin
                            f = 1;
                            mcode[m] = int'(ex[h][31:1]);
                            mhart[m] = h;
                        end
                    end else begin
                        anyzero = 1;
                    end
                end
            end
            if (f) begin
                md[m] = 1;
            end else if (wa[m] ? (&mrep[m]) : anyzero) begin
                md[m] = 1;
                mp[m] = 1;
            end else if (to_lim[m] != 0 && k == to_lim[m]) begin
                md[m] = 1;
                mt[m] = 1;
            end
        end
        e[m]++;
    endtask

    task automatic cmp(input int m, input logic crn, input logic rtc, input logic dn,
                       input logic ps, input logic tmo, input logic [30:0] code,
                       input logic hart, input logic [1:0] rep);
        check($sformatf("m%0d_core_rst_no", m), 32'(crn), 32'(e[m] >= HOLDC));
        check($sformatf("m%0d_rtc", m), 32'(rtc), 32'((e[m] / (DIVC / 2)) % 2));
        check($sformatf("m%0d_done", m), 32'(dn), 32'(md[m]));
        check($sformatf("m%0d_pass", m), 32'(ps), 32'(mp[m]));
        check($sformatf("m%0d_timeout", m), 32'(tmo), 32'(mt[m]));
        check($sformatf("m%0d_fail_code", m), 32'(code), 32'(mcode[m]));
        check($sformatf("m%0d_fail_hart", m), 32'(hart), 32'(mhart[m]));
        check($sformatf("m%0d_reported", m), 32'(rep), 32'(mrep[m]));
    endtask

    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                model_step(0, exit_a);
                model_step(1, exit_b);
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                cmp(0, crn_a, rtc_a, done_a, pass_a, to_a, code_a, hart_a, rep_a);
                cmp(1, crn_b, rtc_b, done_b, pass_b, to_b, code_b, hart_b, rep_b);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        exit_a = '0;
        exit_b = '0;
        model_reset();
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0;
        exit_a = '0;
        exit_b = '0;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // Reset sequencing and RTC start.
        for (int i = 1; i <= 5; i++) begin
            tick();
            if (i == 3) check("hold_edge3", 32'(crn_a), 32'd0);
            if (i == 4) check("hold_edge4", 32'(crn_a), 32'd1);
            if (i == 4) check("rtc_edge4", 32'(rtc_a), 32'd0);
            if (i == 5) check("rtc_edge5", 32'(rtc_a), 32'd1);
        end
        $display("phase reset-seq done at %0t", $time);

        // WaitAll=1 needs both harts; WaitAll=0 passes on the first zero code.
        @(negedge clk);
        exit_a[0] = 32'h1;
        exit_b[1] = 32'h1;
        tick();
        check("b_first_done", 32'(done_b), 32'd1);
        check("b_first_pass", 32'(pass_b), 32'd1);
        check("b_first_rep", 32'(rep_b), 32'd2);
        repeat (3) tick();
        check("a_one_hart_done", 32'(done_a), 32'd0);
        @(negedge clk);
        exit_a[1] = 32'h1;
        tick();
        check("a_all_done", 32'(done_a), 32'd1);
        check("a_all_pass", 32'(pass_a), 32'd1);
        check("a_all_code", 32'(code_a), 32'd0);
        $display("phase pass done at %0t", $time);

        // Simultaneous fails; exit raised during HOLD sampled in first RUN cycle.
        do_reset();
        exit_b[0] = 32'h3;
        for (int i = 1; i <= 5; i++) begin
            tick();
            if (i == 4) check("b_hold_exit_edge4", 32'(done_b), 32'd0);
            if (i == 5) check("b_hold_exit_edge5", 32'(done_b), 32'd1);
            if (i == 5) check("b_hold_exit_code", 32'(code_b), 32'd1);
        end
        @(negedge clk);
        exit_a[0] = 32'h7;
        exit_a[1] = 32'hB;
        tick();
        check("a_dualfail_done", 32'(done_a), 32'd1);
        check("a_dualfail_hart", 32'(hart_a), 32'd0);
        check("a_dualfail_code", 32'(code_a), 32'd3);
        check("a_dualfail_pass", 32'(pass_a), 32'd0);
        $display("phase fail done at %0t", $time);

        // Watchdog after the 20th RUN cycle, then late exits ignored.
        do_reset();
        repeat (23) tick();
        check("a_wd_edge23", 32'(done_a), 32'd0);
        tick();
        check("a_wd_done", 32'(done_a), 32'd1);
        check("a_wd_timeout", 32'(to_a), 32'd1);
        check("a_wd_pass", 32'(pass_a), 32'd0);
        @(negedge clk);
        exit_a[0] = 32'h1;
        exit_a[1] = 32'h1;
        repeat (3) tick();
        check("a_late_pass", 32'(pass_a), 32'd0);
        check("a_late_rep", 32'(rep_a), 32'd0);
        check("a_late_timeout", 32'(to_a), 32'd1);
        check("b_nowd_done", 32'(done_b), 32'd0);
        $display("phase watchdog done at %0t", $time);

        // Asynchronous reset from DONE, then HOLD repeats.
        @(negedge clk);
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        check("rst_crn", 32'(crn_a), 32'd0);
        check("rst_rtc", 32'(rtc_a), 32'd0);
        check("rst_done", 32'(done_a), 32'd0);
        check("rst_pass", 32'(pass_a), 32'd0);
        check("rst_timeout", 32'(to_a), 32'd0);
        check("rst_code", 32'(code_a), 32'd0);
        check("rst_hart", 32'(hart_a), 32'd0);
        check("rst_rep", 32'(rep_a), 32'd0);
        @(negedge clk);
        exit_a = '0;
        exit_b = '0;
        rst = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            if (i == 3) check("rehold_edge3", 32'(crn_a), 32'd0);
            if (i == 4) check("rehold_edge4", 32'(crn_a), 32'd1);
        end
        $display("phase re-reset done at %0t", $time);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
